// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared FSM encoding, register address width and stall/flush bundle
package hazard_control_unit_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} hcu_state_e;
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_wb;
  } hazard_ctrl_t;
endpackage

// File: rtl/hazard_control_unit_mem_wait_watchdog.sv
// mem_wait_watchdog: tracks dmem wait cycles and halts the core on a memory timeout
module mem_wait_watchdog
  import hazard_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic dmem_ready,
  output logic mem_wait,
  output logic halt,
  output logic mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  hcu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_err_q;
  always_comb begin
    mem_wait = mem_req && !dmem_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_RUN: begin
        state_d = mem_wait ? ST_WAIT : ST_RUN;
        cnt_d   = mem_wait ? CW'(1) : '0;
      end
      ST_WAIT: begin
        state_d = dmem_ready ? ST_RUN : (cnt_q == CW'(MEM_TIMEOUT - 1)) ? ST_HALT : ST_WAIT;
        cnt_d   = dmem_ready ? '0 : cnt_q + CW'(1);
      end
      default: state_d = ST_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= state_q == ST_WAIT && state_d == ST_HALT;
    end
  end
  assign halt    = state_q == ST_HALT;
  assign mem_err = mem_err_q;
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush/freeze control for load-use, branch, dmem wait and timeout
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Raddr1_D,
  input  logic [REG_ADDR_W-1:0] Raddr2_D,
  input  logic                  Use1_D,
  input  logic                  Use2_D,
  input  logic [REG_ADDR_W-1:0] Waddr_E,
  input  logic                  MemRead_E,
  input  logic                  PCSrc_E,
  input  logic                  MemReq_M,
  input  logic                  dmem_ready,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushWB,
  output logic                  Halt,
  output logic                  MemErr,
  output logic [CNT_W-1:0]      StallCycles
);
  logic mem_wait, halt, mem_err, lu;
  hazard_ctrl_t hc;
  logic [CNT_W-1:0] cnt_q;
  mem_wait_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (MemReq_M),
    .dmem_ready(dmem_ready),
    .mem_wait  (mem_wait),
    .halt      (halt),
    .mem_err   (mem_err)
  );
  assign lu = MemRead_E && Waddr_E != '0 &&
              ((Use1_D && Raddr1_D == Waddr_E) || (Use2_D && Raddr2_D == Waddr_E));
  always_comb begin
    hc = '0;
    if (rst)
      hc = '0;
    else if (halt || mem_wait)
      hc = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1, flush_wb: 1'b1, default: 1'b0};
    else if (PCSrc_E)
      hc = '{flush_d: 1'b1, flush_e: 1'b1, default: 1'b0};
    else if (lu)
      hc = '{stall_f: 1'b1, stall_d: 1'b1, flush_e: 1'b1, default: 1'b0};
  end
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : (hc.stall_f && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign StallF      = hc.stall_f;
  assign StallD      = hc.stall_d;
  assign StallE      = hc.stall_e;
  assign StallM      = hc.stall_m;
  assign FlushD      = hc.flush_d;
  assign FlushE      = hc.flush_e;
  assign FlushWB     = hc.flush_wb;
  assign Halt        = halt && !rst;
  assign MemErr      = mem_err && !rst;
  assign StallCycles = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench for hazard_control_unit (MEM_TIMEOUT=4, CNT_W=4)
module tb_hazard_control_unit;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Raddr1_D, Raddr2_D, Waddr_E;
  logic Use1_D, Use2_D, MemRead_E, PCSrc_E, MemReq_M, dmem_ready;
  logic StallF, StallD, FlushD, FlushE, StallE, StallM, FlushWB, Halt, MemErr;
  logic [3:0] StallCycles;
  int checks = 0;
  int failures = 0;
  // expected order: StallF StallD StallE StallM FlushD FlushE FlushWB Halt MemErr
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] BR   = 9'b000011000;
  localparam logic [8:0] FRZ  = 9'b111100100;
  localparam logic [8:0] HLT  = 9'b111100110;
  localparam logic [8:0] HLTE = 9'b111100111;
  typedef struct {
    string      tag;
    logic [8:0] o;
    logic [3:0] c;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  always #5 clk = ~clk;
  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Raddr1_D(Raddr1_D), .Raddr2_D(Raddr2_D), .Use1_D(Use1_D),
    .Use2_D(Use2_D), .Waddr_E(Waddr_E), .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E),
    .MemReq_M(MemReq_M), .dmem_ready(dmem_ready), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .StallE(StallE), .StallM(StallM), .FlushWB(FlushWB),
    .Halt(Halt), .MemErr(MemErr), .StallCycles(StallCycles)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      cur = q.pop_front();
      check({cur.tag, "_ctl"}, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushWB, Halt, MemErr}), 32'(cur.o));
      check({cur.tag, "_cnt"}, 32'(StallCycles), 32'(cur.c));
    end
  task automatic cyc(input string tag, input logic r, input logic [4:0] ra1, input logic [4:0] ra2,
                     input logic u1, input logic u2, input logic [4:0] wa, input logic mr,
                     input logic pc, input logic req, input logic rdy,
                     input logic [8:0] eo, input logic [3:0] ec);
    @(posedge clk);
    #1;
    rst = r; Raddr1_D = ra1; Raddr2_D = ra2; Use1_D = u1; Use2_D = u2; Waddr_E = wa;
    MemRead_E = mr; PCSrc_E = pc; MemReq_M = req; dmem_ready = rdy;
    q.push_back('{tag, eo, ec});
  endtask
  task automatic idle(input string tag, input logic [8:0] eo, input logic [3:0] ec);
    cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, eo, ec);
  endtask
  task automatic reset_cyc(input string tag);
    cyc(tag, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, NONE, 4'd0);
  endtask
  task automatic mem(input string tag, input logic pc, input logic rdy, input logic [8:0] eo, input logic [3:0] ec);
    cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, pc, 1'b1, rdy, eo, ec);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end
  initial begin
    rst = 1'b1; Raddr1_D = '0; Raddr2_D = '0; Use1_D = 0; Use2_D = 0; Waddr_E = '0;
    MemRead_E = 0; PCSrc_E = 0; MemReq_M = 0; dmem_ready = 1;
    reset_cyc("rst");
    cyc("lu1", 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 1, LU, 4'd0);
    idle("lu1_after", NONE, 4'd1);
    cyc("lu_use0", 0, 5'd5, 5'd0, 0, 0, 5'd5, 1, 0, 0, 1, NONE, 4'd1);
    cyc("lu_x0", 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 1, NONE, 4'd1);
    cyc("lu_notload", 0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 1, NONE, 4'd1);
    cyc("lu_rs2", 0, 5'd3, 5'd7, 1, 1, 5'd7, 1, 0, 0, 1, LU, 4'd1);
    cyc("br_lu", 0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0, 1, BR, 4'd2);
    idle("br_after", NONE, 4'd2);
    mem("req_rdy", 0, 1, NONE, 4'd2);
    idle("req_rdy_after", NONE, 4'd2);
    reset_cyc("rst_mw");
    for (int i = 0; i < 3; i++) mem($sformatf("mw%0d", i), 1, 0, FRZ, 4'(i));
    mem("mw_rel", 1, 1, BR, 4'd3);
    idle("mw_done", NONE, 4'd3);
    reset_cyc("rst_to");
    for (int i = 0; i < 4; i++) mem($sformatf("to%0d", i), 0, 0, FRZ, 4'(i));
    mem("to_err", 0, 0, HLTE, 4'd4);
    mem("to_halt", 0, 0, HLT, 4'd5);
    mem("to_rdy", 1, 1, HLT, 4'd6);
    idle("to_idle", HLT, 4'd7);
    reset_cyc("to_rst");
    idle("to_clear", NONE, 4'd0);
    mem("rmw0", 0, 0, FRZ, 4'd0);
    mem("rmw1", 0, 0, FRZ, 4'd1);
    cyc("rmw_rst", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, NONE, 4'd0);
    idle("rmw_after", NONE, 4'd0);
    for (int i = 0; i < 3; i++) mem($sformatf("rmw_w%0d", i), 0, 0, FRZ, 4'(i));
    mem("rmw_rel", 0, 1, NONE, 4'd3);
    idle("rmw_norun", NONE, 4'd3);
    reset_cyc("rst_sat");
    for (int i = 0; i < 20; i++)
      cyc($sformatf("sat%0d", i), 0, 5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1, LU, 4'(i > 15 ? 15 : i));
    idle("sat_end", NONE, 4'd15);
    @(posedge clk);
    @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
